// File: rtl/demux_seq.sv
`default_nettype none
// ============================================================================
// Module      : demux_seq
// Description : Registered 1-of-2^AW decoder/demultiplexer with address latch,
//               selectable output polarity, timed single-strobe mode and a
//               scan mode that walks every output in turn.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_seq #(
    parameter int AW      = 3,
    parameter int PULSE_W = 1,
    parameter int POL     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  g1,
    input  logic                  ng2a,
    input  logic                  ng2b,
    input  logic                  le,
    input  logic [AW-1:0]         a,
    input  logic [1:0]            mode,
    input  logic                  start,
    output logic [(1<<AW)-1:0]    y,
    output logic [AW-1:0]         idx,
    output logic                  busy,
    output logic                  done
);

    localparam int c_n  = 1 << AW;
    localparam int c_cw = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    localparam logic [c_cw-1:0] c_cnt_reload = c_cw'(PULSE_W - 1);
    localparam logic [c_cw-1:0] c_cnt_one    = c_cw'(1);
    localparam logic [AW-1:0]   c_idx_one    = AW'(1);
    localparam logic [AW-1:0]   c_idx_last   = {AW{1'b1}};
    localparam logic [c_n-1:0]  c_inactive   = (POL != 0) ? {c_n{1'b1}} : {c_n{1'b0}};

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_strobe = 2'd1;
    localparam logic [1:0] c_st_scan   = 2'd2;

    localparam logic [1:0] c_mode_strobe = 2'd1;
    localparam logic [1:0] c_mode_scan   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [c_cw-1:0] cnt_q,   cnt_d;
    logic [AW-1:0]   idx_q,   idx_d;
    logic [c_n-1:0]  y_q,     y_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic            w_en;
    logic [AW-1:0]   w_ea;

    // Active pattern for a single selected output, already in output polarity
    function automatic logic [c_n-1:0] onehot_pol(input logic [AW-1:0] k);
        logic [c_n-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return (POL != 0) ? ~v : v;
    endfunction

    assign w_en = g1 & ~ng2a & ~ng2b;
    // A transparent latch-enable lets the new address take effect on this edge
    assign w_ea = le ? a : addr_q;

    // Next-state decode for the IDLE / STROBE / SCAN controller
    always_comb begin
        state_d = state_q;
        addr_d  = w_ea;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            c_st_strobe: begin
                if (!w_en) begin
                    // Abort: drop the select immediately, no completion pulse
                    state_d = c_st_idle;
                    y_d     = c_inactive;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cnt_one;
                end else begin
                    state_d = c_st_idle;
                    y_d     = c_inactive;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            c_st_scan: begin
                if (!w_en) begin
                    state_d = c_st_idle;
                    y_d     = c_inactive;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cnt_one;
                end else if (idx_q != c_idx_last) begin
                    // Hand over to the next output on the same edge: no gap
                    idx_d = idx_q + c_idx_one;
                    cnt_d = c_cnt_reload;
                    y_d   = onehot_pol(idx_q + c_idx_one);
                end else begin
                    state_d = c_st_idle;
                    y_d     = c_inactive;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                idx_d = w_ea;
                y_d   = c_inactive;
                case (mode)
                    c_mode_strobe: begin
                        if (start && w_en) begin
                            state_d = c_st_strobe;
                            cnt_d   = c_cnt_reload;
                            y_d     = onehot_pol(w_ea);
                            busy_d  = 1'b1;
                        end
                    end
                    c_mode_scan: begin
                        if (start && w_en) begin
                            state_d = c_st_scan;
                            idx_d   = '0;
                            cnt_d   = c_cnt_reload;
                            y_d     = onehot_pol('0);
                            busy_d  = 1'b1;
                        end
                    end
                    default: begin
                        // Plain decode (mode 0 and the reserved mode 3)
                        if (w_en) begin
                            y_d = onehot_pol(w_ea);
                        end
                    end
                endcase
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_st_idle;
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            y_q     <= c_inactive;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_seq
// Description : Self-checking bench for demux_seq. Two instances share stimulus:
//               inst0 (PULSE_W=3, active-high) and inst1 (PULSE_W=2,
//               active-low). A cycle-count reference model predicts both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       g1, ng2a, ng2b, le, start;
    logic [2:0] a;
    logic [1:0] mode;

    logic [7:0] y0, y1;
    logic [2:0] idx0, idx1;
    logic       busy0, busy1, done0, done1;

    int n_total = 0;
    int n_bad   = 0;

    demux_seq #(.AW(3), .PULSE_W(3), .POL(0)) u_dut0 (
        .clk(clk), .reset(reset), .g1(g1), .ng2a(ng2a), .ng2b(ng2b), .le(le),
        .a(a), .mode(mode), .start(start),
        .y(y0), .idx(idx0), .busy(busy0), .done(done0)
    );

    demux_seq #(.AW(3), .PULSE_W(2), .POL(1)) u_dut1 (
        .clk(clk), .reset(reset), .g1(g1), .ng2a(ng2a), .ng2b(ng2b), .le(le),
        .a(a), .mode(mode), .start(start),
        .y(y1), .idx(idx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    logic [12:0] obs [2];
    assign obs[0] = {y0, idx0, busy0, done0};
    assign obs[1] = {y1, idx1, busy1, done1};

    // Reference model: phase 0 idle, 1 strobe, 2 scan
    int         pw  [2] = '{3, 2};
    bit         pol [2] = '{1'b0, 1'b1};
    int         m_phase [2];
    int         m_remain[2];   // strobe cycles still to be shown
    int         m_t     [2];   // cycles elapsed since scan start
    int         m_sel   [2];   // selected output, -1 when none
    logic [2:0] m_addr  [2];
    logic [2:0] m_idx   [2];
    bit         m_busy  [2];
    bit         m_done  [2];

    function automatic logic [12:0] expect_of(input int k);
        logic [7:0] v;
        v = 8'h00;
        if (m_sel[k] >= 0) v[m_sel[k]] = 1'b1;
        if (pol[k]) v = ~v;
        return {v, m_idx[k], m_busy[k], m_done[k]};
    endfunction

    task automatic model_step();
        bit         en;
        logic [2:0] ea;
        for (int k = 0; k < 2; k++) begin
            en = g1 && !ng2a && !ng2b;
            ea = le ? a : m_addr[k];
            if (reset) begin
                m_phase[k] = 0; m_remain[k] = 0; m_t[k] = 0; m_sel[k] = -1;
                m_addr[k] = 3'd0; m_idx[k] = 3'd0; m_busy[k] = 0; m_done[k] = 0;
            end else begin
                m_done[k] = 0;
                if (m_phase[k] != 0 && !en) begin
                    m_phase[k] = 0; m_sel[k] = -1; m_busy[k] = 0;
                end else if (m_phase[k] == 1) begin
                    m_remain[k] = m_remain[k] - 1;
                    if (m_remain[k] == 0) begin
                        m_phase[k] = 0; m_sel[k] = -1; m_busy[k] = 0; m_done[k] = 1;
                    end
                end else if (m_phase[k] == 2) begin
                    m_t[k] = m_t[k] + 1;
                    if (m_t[k] == 8 * pw[k]) begin
                        m_phase[k] = 0; m_sel[k] = -1; m_busy[k] = 0; m_done[k] = 1;
                    end else begin
                        m_sel[k] = m_t[k] / pw[k];
                        m_idx[k] = 3'(m_sel[k]);
                    end
                end else begin
                    m_idx[k] = ea;
                    if (start && en && mode == 2'd1) begin
                        m_phase[k] = 1; m_remain[k] = pw[k]; m_sel[k] = int'(ea); m_busy[k] = 1;
                    end else if (start && en && mode == 2'd2) begin
                        m_phase[k] = 2; m_t[k] = 0; m_sel[k] = 0; m_idx[k] = 3'd0; m_busy[k] = 1;
                    end else if ((mode == 2'd0 || mode == 2'd3) && en) begin
                        m_sel[k] = int'(ea);
                    end else begin
                        m_sel[k] = -1;
                    end
                end
                if (le) m_addr[k] = a;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle_inputs();
        reset = 1'b0; g1 = 1'b1; ng2a = 1'b0; ng2b = 1'b0;
        le = 1'b0; a = 3'd0; mode = 2'd0; start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; g1 = 1'b1; ng2a = 1'b0; ng2b = 1'b0;
        le = 1'b1; a = 3'd7; mode = 2'd0; start = 1'b1;
        tick(); tick();
        n_total++;
        if (obs[0] !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset inst0: got %h want %h", obs[0], 13'h0);
        end
        n_total++;
        if (obs[1] !== {8'hFF, 3'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset inst1: got %h want %h", obs[1], {8'hFF, 5'd0});
        end
        reset = 1'b0; start = 1'b0;
    endtask

    task automatic test_decode_sweep();
        logic [5:0] v;
        set_idle_inputs();
        le = 1'b1;
        for (int i = 0; i < 64; i++) begin
            v = 6'(i);
            g1 = v[5]; ng2a = v[4]; ng2b = v[3]; a = v[2:0];
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs[k] !== expect_of(k)) begin
                    n_bad++;
                    $display("FAIL decode[%0d] inst%0d: got %h want %h", i, k, obs[k], expect_of(k));
                end
            end
        end
    endtask

    task automatic test_latch();
        set_idle_inputs();
        le = 1'b1; a = 3'd5;
        tick();
        le = 1'b0; a = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (y0 !== 8'b0010_0000 || y1 !== 8'b1101_1111 || obs[0] !== expect_of(0)) begin
                n_bad++;
                $display("FAIL latch[%0d]: got y0=%b y1=%b want y0=00100000 y1=11011111", i, y0, y1);
            end
        end
    endtask

    task automatic test_strobe();
        int busy_cnt = 0;
        int done_at  = -1;
        set_idle_inputs();
        le = 1'b1; a = 3'd6;
        tick();
        le = 1'b0; a = 3'd1; mode = 2'd1; start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 2) start = 1'b0;   // start held during busy for one cycle
            if (busy0) busy_cnt++;
            if (done0 && done_at < 0) done_at = i;
            if (i <= 3) begin
                n_total++;
                if (y0 !== 8'b0100_0000) begin
                    n_bad++; $display("FAIL strobe_y[%0d]: got %b want 01000000", i, y0);
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs[k] !== expect_of(k)) begin
                    n_bad++;
                    $display("FAIL strobe[%0d] inst%0d: got %h want %h", i, k, obs[k], expect_of(k));
                end
            end
        end
        n_total++;
        if (busy_cnt != 3 || done_at != 4) begin
            n_bad++;
            $display("FAIL strobe_timing: got busy=%0d done_at=%0d want busy=3 done_at=4", busy_cnt, done_at);
        end
    endtask

    task automatic test_scan();
        logic [7:0] w;
        set_idle_inputs();
        mode = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 26; j++) begin
            if (j <= 16) begin
                w = 8'h01 << ((j - 1) / 2);
                n_total++;
                if (y1 !== ~w || busy1 !== 1'b1) begin
                    n_bad++; $display("FAIL scan_walk[%0d]: got y1=%b busy=%b want y1=%b busy=1", j, y1, busy1, ~w);
                end
            end else if (j == 17) begin
                n_total++;
                if (y1 !== 8'hFF || done1 !== 1'b1 || busy1 !== 1'b0) begin
                    n_bad++; $display("FAIL scan_end: got y1=%h done=%b busy=%b want FF 1 0", y1, done1, busy1);
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs[k] !== expect_of(k)) begin
                    n_bad++;
                    $display("FAIL scan[%0d] inst%0d: got %h want %h", j, k, obs[k], expect_of(k));
                end
            end
            tick();
        end
    endtask

    task automatic test_abort();
        int guard = 0;
        set_idle_inputs();
        mode = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        while (idx1 !== 3'd4 && guard < 20) begin
            tick();
            guard++;
        end
        n_total++;
        if (guard >= 20) begin
            n_bad++; $display("FAIL abort_wait: got idx1=%0d want 4 within 20 cycles", idx1);
        end
        ng2a = 1'b1;
        tick();
        n_total++;
        if (y1 !== 8'hFF || busy1 !== 1'b0 || done1 !== 1'b0 || y0 !== 8'h00 || busy0 !== 1'b0) begin
            n_bad++; $display("FAIL abort: got y1=%h busy1=%b done1=%b y0=%h want FF 0 0 00", y1, busy1, done1, y0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs[k] !== expect_of(k)) begin
                    n_bad++;
                    $display("FAIL abort_after[%0d] inst%0d: got %h want %h", i, k, obs[k], expect_of(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        set_idle_inputs();
        le = 1'b1; a = 3'd6; mode = 2'd1; start = 1'b1;
        tick();
        le = 1'b0; start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_total++;
        if (obs[0] !== 13'h0 || y1 !== 8'hFF || idx1 !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid: got inst0=%h inst1=%h want 0000 and FF/0/0/0", obs[0], obs[1]);
        end
        reset = 1'b0; mode = 2'd0; a = 3'd5;
        tick();
        n_total++;
        if (y0 !== 8'h01 || idx0 !== 3'd0) begin
            n_bad++; $display("FAIL reset_addr: got y0=%h idx0=%0d want 01 0", y0, idx0);
        end
    endtask

    task automatic test_back_to_back();
        set_idle_inputs();
        le = 1'b1; a = 3'd3; mode = 2'd1; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs[k] !== expect_of(k)) begin
                    n_bad++;
                    $display("FAIL b2b[%0d] inst%0d: got %h want %h", i, k, obs[k], expect_of(k));
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            g1    = ($urandom_range(0, 15) != 0);
            ng2a  = ($urandom_range(0, 23) == 0);
            ng2b  = ($urandom_range(0, 23) == 0);
            le    = ($urandom_range(0, 3) == 0);
            a     = 3'($urandom_range(0, 7));
            mode  = 2'($urandom_range(0, 3));
            start = ($urandom_range(0, 3) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs[k] !== expect_of(k)) begin
                    n_bad++;
                    $display("FAIL random[%0d] inst%0d: got %h want %h", i, k, obs[k], expect_of(k));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_remain[k] = 0; m_t[k] = 0; m_sel[k] = -1;
            m_addr[k] = 3'd0; m_idx[k] = 3'd0; m_busy[k] = 0; m_done[k] = 0;
        end
        set_idle_inputs();
        @(negedge clk);
        test_reset();
        test_decode_sweep();
        test_latch();
        test_strobe();
        test_scan();
        test_abort();
        test_reset_mid_strobe();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
